// File: rtl/replica_sched.sv
// Round-robin grant scheduler for the replica routing mux: one grant per cycle,
// beat counting per frame, and valid/last aligned to the router's output register.
module replica_sched #(
  parameter int unsigned REPLICA = 8,
  parameter int unsigned REPLLEN = 4,
  parameter int unsigned CNTLEN  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNTLEN-1:0]  frame_len,
  input  logic [REPLICA-1:0] req,
  input  logic               out_ready,
  output logic [REPLICA-1:0] grant,
  output logic [REPLLEN-1:0] mux,
  output logic               out_valid,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [REPLLEN-1:0] ptr_q, ptr_d;
  logic [REPLLEN-1:0] mux_q, mux_d;
  logic [CNTLEN-1:0]  cnt_q, cnt_d;
  logic [CNTLEN-1:0]  flen_q, flen_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;

  logic               found_hi;
  logic [REPLLEN-1:0] idx_hi, idx_lo;
  logic [REPLLEN-1:0] winner;
  logic [REPLLEN-1:0] ptr_inc;
  logic [CNTLEN-1:0]  cnt_inc;
  logic               grant_en;

  // Rotating priority: lowest set bit at or above ptr wins, else lowest set bit below ptr.
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = REPLICA - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i >= int'(ptr_q)) begin
          found_hi = 1'b1;
          idx_hi   = REPLLEN'(i);
        end else begin
          idx_lo = REPLLEN'(i);
        end
      end
    end
    winner = found_hi ? idx_hi : idx_lo;
  end

  assign grant_en = (state_q == StRun) && out_ready && (|req);
  assign ptr_inc  = (winner == REPLLEN'(REPLICA - 1)) ? '0 : winner + 1'b1;
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mux_d       = mux_q;
    cnt_d       = cnt_q;
    flen_d      = flen_q;
    out_valid_d = grant_en;
    out_last_d  = grant_en && (cnt_inc == flen_q);
    case (state_q)
      StIdle: begin
        if (start) begin
          flen_d  = frame_len;
          cnt_d   = '0;
          state_d = (frame_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (grant_en) begin
          cnt_d = cnt_inc;
          ptr_d = ptr_inc;
          mux_d = winner;
          if (cnt_inc == flen_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      mux_q       <= '0;
      cnt_q       <= '0;
      flen_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mux_q       <= mux_d;
      cnt_q       <= cnt_d;
      flen_q      <= flen_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Hold the last granted index on idle cycles so the router select never glitches.
  assign mux       = grant_en ? winner : mux_q;
  assign grant     = grant_en ? (REPLICA'(1) << winner) : '0;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_replica_sched.sv
// Directed bench for replica_sched: reset abort, full sweep, wrap fairness,
// back-pressure stalls, empty frame and start-while-busy.
module tb_replica_sched;

  localparam int unsigned REPLICA = 8;
  localparam int unsigned REPLLEN = 4;
  localparam int unsigned CNTLEN  = 10;

  logic               clk;
  logic               rst;
  logic               start;
  logic [CNTLEN-1:0]  frame_len;
  logic [REPLICA-1:0] req;
  logic               out_ready;
  logic [REPLICA-1:0] grant;
  logic [REPLLEN-1:0] mux;
  logic               out_valid;
  logic               out_last;
  logic               busy;
  logic               done;

  int n_checks;
  int n_errors;

  replica_sched #(
    .REPLICA(REPLICA),
    .REPLLEN(REPLLEN),
    .CNTLEN (CNTLEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .frame_len(frame_len),
    .req      (req),
    .out_ready(out_ready),
    .grant    (grant),
    .mux      (mux),
    .out_valid(out_valid),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] onehot(input int idx);
    return 32'(1) << idx;
  endfunction

  // Frame with per-cycle expected winner indices; req/out_ready held high.
  int          t3_exp [4]   = '{0, 7, 0, 7};
  int          t6_exp [5]   = '{0, 1, 2, 3, 0};
  logic        t4_rdy [4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] t4_gnt [4]   = '{32'h02, 32'h00, 32'h00, 32'h04};
  logic [31:0] t4_mux [4]   = '{32'd1, 32'd1, 32'd1, 32'd2};
  logic [31:0] t4_vld [4]   = '{32'd0, 32'd1, 32'd0, 32'd0};

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    frame_len = '0;
    req       = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_mux", 32'(mux), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // T1: reset mid-frame after three beats
    frame_len = 10'd8;
    req       = 8'hFF;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("t1_pre_valid", 32'(out_valid), 32'd1);
    check("t1_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t1_async_valid", 32'(out_valid), 32'd0);
    check("t1_async_grant", 32'(grant), 32'd0);
    tick();
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_mux", 32'(mux), 32'd0);
    check("t1_last", 32'(out_last), 32'd0);
    check("t1_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // T2: full sweep 0..7
    frame_len = 10'd8;
    req       = 8'hFF;
    out_ready = 1'b1;
    start     = 1'b1;
    #1;
    check("t2_idle_grant", 32'(grant), 32'd0);
    tick();
    start = 1'b0;
    #1;
    for (int b = 0; b < 8; b++) begin
      check("t2_grant", 32'(grant), onehot(b));
      check("t2_mux", 32'(mux), 32'(b));
      check("t2_valid", 32'(out_valid), (b > 0) ? 32'd1 : 32'd0);
      check("t2_last", 32'(out_last), 32'd0);
      tick();
      #1;
    end
    check("t2_drain_valid", 32'(out_valid), 32'd1);
    check("t2_drain_last", 32'(out_last), 32'd1);
    check("t2_drain_grant", 32'(grant), 32'd0);
    check("t2_drain_mux", 32'(mux), 32'd7);
    check("t2_drain_done", 32'(done), 32'd0);
    tick();
    check("t2_done", 32'(done), 32'd1);
    check("t2_done_busy", 32'(busy), 32'd1);
    check("t2_done_valid", 32'(out_valid), 32'd0);
    tick();
    check("t2_idle_done", 32'(done), 32'd0);
    check("t2_idle_busy", 32'(busy), 32'd0);

    // T3: wrap fairness between replicas 0 and 7
    frame_len = 10'd4;
    req       = 8'b1000_0001;
    start     = 1'b1;
    tick();
    start = 1'b0;
    #1;
    for (int b = 0; b < 4; b++) begin
      check("t3_grant", 32'(grant), onehot(t3_exp[b]));
      check("t3_mux", 32'(mux), 32'(t3_exp[b]));
      tick();
      #1;
    end
    check("t3_last", 32'(out_last), 32'd1);
    tick();
    check("t3_done", 32'(done), 32'd1);
    tick();
    check("t3_idle", 32'(busy), 32'd0);

    // T6: restart attempt mid-frame is ignored, frame_len not resampled
    frame_len = 10'd5;
    req       = 8'h0F;
    start     = 1'b1;
    tick();
    start = 1'b0;
    #1;
    for (int b = 0; b < 5; b++) begin
      check("t6_grant", 32'(grant), onehot(t6_exp[b]));
      check("t6_last", 32'(out_last), 32'd0);
      check("t6_busy", 32'(busy), 32'd1);
      start = (b == 2);
      if (b == 2) frame_len = 10'd2;
      tick();
      #1;
    end
    start = 1'b0;
    check("t6_drain_last", 32'(out_last), 32'd1);
    tick();
    check("t6_done", 32'(done), 32'd1);
    tick();
    check("t6_idle", 32'(busy), 32'd0);

    // T4: back-pressure, ptr now 1 so the held select is nonzero
    frame_len = 10'd2;
    req       = 8'h0F;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      out_ready = t4_rdy[c];
      #1;
      check("t4_grant", 32'(grant), t4_gnt[c]);
      check("t4_mux", 32'(mux), t4_mux[c]);
      check("t4_valid", 32'(out_valid), t4_vld[c]);
      check("t4_last", 32'(out_last), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("t4_drain_valid", 32'(out_valid), 32'd1);
    check("t4_drain_last", 32'(out_last), 32'd1);
    tick();
    check("t4_done", 32'(done), 32'd1);
    tick();
    check("t4_idle", 32'(busy), 32'd0);

    // T5: empty frame goes straight to done with no grant
    frame_len = 10'd0;
    req       = 8'hFF;
    start     = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("t5_grant", 32'(grant), 32'd0);
    check("t5_done", 32'(done), 32'd1);
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_valid", 32'(out_valid), 32'd0);
    tick();
    check("t5_done_clr", 32'(done), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_idle_grant", 32'(grant), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
